// File: rtl/core_pkg.sv
// Shared core types and constants for the instruction fetch path.
package core_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with clear, full/empty and count.
module fetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_clear,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_do_push;
  logic          w_do_pop;
  logic [AW-1:0] w_rd_ptr_inc;
  logic [AW-1:0] w_wr_ptr_inc;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign w_rd_ptr_inc = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
  assign w_wr_ptr_inc = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_do_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Entry storage; left unreset since occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order PC tagging,
// flush/redirect with discard of stale responses, buffered hand-off to decode.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            jump,
  input  logic            stall_n,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Fetch PC, request/response counters and the in-order tag queue.
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard_cnt;
  logic [XLEN-1:0] r_tag_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_tag_rd;
  logic [AW-1:0]   r_tag_wr;

  logic            w_req;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW:0]     w_credit_used;
  logic [CW-1:0]   w_out_after_rv;
  logic [AW-1:0]   w_tag_rd_inc;
  logic [AW-1:0]   w_tag_wr_inc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;

  // Outstanding requests (including ones to be discarded) and buffered
  // entries share one credit pool, so a granted response always has room.
  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_req          = rst_n && !flush && (w_credit_used < (CW + 1)'(FIFO_DEPTH));
  assign w_grant        = w_req && imem_gnt;

  // Responses are dropped during a flush and while stale ones are draining.
  assign w_push         = imem_rvalid && !flush && (r_discard_cnt == '0);
  assign w_out_after_rv = r_outstanding - CW'(imem_rvalid);

  assign w_valid        = !w_fifo_empty && !flush;
  assign w_pop          = w_valid && stall_n;

  assign w_tag_rd_inc   = (r_tag_rd == AW'(FIFO_DEPTH - 1)) ? '0 : r_tag_rd + AW'(1);
  assign w_tag_wr_inc   = (r_tag_wr == AW'(FIFO_DEPTH - 1)) ? '0 : r_tag_wr + AW'(1);

  assign w_push_entry.pc    = r_tag_mem[r_tag_rd];
  assign w_push_entry.instr = imem_rdata;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = w_valid;
  assign if_pc     = w_valid ? w_head.pc    : '0;
  assign if_instr  = w_valid ? w_head.instr : '0;

  // Fetch PC: a redirect wins over the post-grant increment (wraps at 2^32).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (jump) begin
      r_pc <= align_word(jump_addr);
    end else if (w_grant) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // Outstanding count and the number of in-flight responses still to be thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_outstanding <= w_out_after_rv + CW'(w_grant);
      if (flush) begin
        r_discard_cnt <= w_out_after_rv;
      end else if (imem_rvalid && (r_discard_cnt != '0)) begin
        r_discard_cnt <= r_discard_cnt - CW'(1);
      end
    end
  end

  // Tag queue pointers: push the PC on grant, pop when its response is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_rd <= '0;
      r_tag_wr <= '0;
    end else if (flush) begin
      r_tag_rd <= '0;
      r_tag_wr <= '0;
    end else begin
      if (w_grant) r_tag_wr <= w_tag_wr_inc;
      if (w_push)  r_tag_rd <= w_tag_rd_inc;
    end
  end

  // Tag storage written with the address being granted.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_clear     (flush),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

`ifndef SYNTHESIS
  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (r_outstanding != '0));
  a_no_push_on_full: assert property (
    @(posedge clk) disable iff (!rst_n) (w_push && w_fifo_full) |-> w_pop);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model and a
// queue-based reference model checked every cycle.
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        jump = 1'b0;
  logic        stall_n = 1'b1;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_addr   (jump_addr),
    .jump        (jump),
    .stall_n     (stall_n),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model (in order, latency 1, can hold) ----------
  logic [31:0] mem_q[$];
  logic        mem_hold = 1'b0;
  logic        smp_grant = 1'b0;
  logic [31:0] smp_addr = '0;

  initial forever begin
    @(negedge clk);
    smp_grant = imem_req && imem_gnt;
    smp_addr  = imem_addr;
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mem_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (imem_rvalid) void'(mem_q.pop_front());
      if (smp_grant) mem_q.push_back(smp_addr);
      #2;
      imem_rvalid = (mem_q.size() > 0) && !mem_hold;
      imem_rdata  = imem_rvalid ? mem_word(mem_q[0]) : 32'h0;
    end
  end

  // ---------------- reference model -------------------------------------
  logic [31:0]  m_pc = RST_PC;
  int           m_out = 0;
  int           m_disc = 0;
  logic [31:0]  m_tag[$];
  fetch_entry_t m_fifo[$];
  fetch_entry_t log_q[$];

  function automatic bit m_req();
    return !flush && ((m_out + m_fifo.size()) < DEPTH);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pc = RST_PC; m_out = 0; m_disc = 0;
      m_tag.delete(); m_fifo.delete();
    end else begin
      bit           g;
      bit           p;
      fetch_entry_t e;
      g = m_req() && imem_gnt;
      p = (m_fifo.size() > 0) && !flush && stall_n;
      if (p) begin
        e = m_fifo.pop_front();
        log_q.push_back(e);
        $display("fetch pc=%h instr=%h", e.pc, e.instr);
      end
      if (imem_rvalid) begin
        m_out--;
        if (!flush) begin
          if (m_disc > 0) m_disc--;
          else begin
            e.pc = m_tag.pop_front();
            e.instr = imem_rdata;
            m_fifo.push_back(e);
          end
        end
      end
      if (flush) begin
        m_fifo.delete(); m_tag.delete();
        m_disc = m_out;
      end
      if (g) begin
        m_tag.push_back(m_pc);
        m_out++;
        m_pc = m_pc + 32'd4;
      end
      if (jump) m_pc = {jump_addr[31:2], 2'b00};
    end
  end

  // ---------------- per-cycle compare ------------------------------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check32("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check32("rst_if_pc", if_pc, 32'd0);
      check32("rst_if_instr", if_instr, 32'd0);
    end else begin
      bit er;
      bit ev;
      er = m_req();
      ev = (m_fifo.size() > 0) && !flush;
      check32("imem_req", {31'b0, imem_req}, {31'b0, er});
      if (er) check32("imem_addr", imem_addr, m_pc);
      check32("if_valid", {31'b0, if_valid}, {31'b0, ev});
      if (ev) begin
        check32("if_pc", if_pc, m_fifo[0].pc);
        check32("if_instr", if_instr, m_fifo[0].instr);
      end
    end
  end

  // ---------------- directed stimulus ------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (log_q.size() < n && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (log_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout presented=%0d required=%0d", name, log_q.size(), n);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] exp_pc);
    if (log_q.size() > idx) check32(name, log_q[idx].pc, exp_pc);
    else check32(name, 32'hDEAD_BEEF, exp_pc);
  endtask

  initial begin
    int n;
    int k;
    logic [31:0] held;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check32("reset_req_lit", {31'b0, imem_req}, 32'd0);
    check32("reset_valid_lit", {31'b0, if_valid}, 32'd0);

    // Streaming fetch from reset
    imem_gnt = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check32("first_req", {31'b0, imem_req}, 32'd1);
    check32("first_addr", imem_addr, RST_PC);
    tick();
    wait_log(3, "stream_wait");
    check_log("stream_pc0", 0, 32'h0);
    check_log("stream_pc1", 1, 32'h4);
    check_log("stream_pc2", 2, 32'h8);
    if (log_q.size() > 0) check32("stream_instr0", log_q[0].instr, 32'h1357_9BDF);

    // Decode stall for five cycles
    stall_n = 1'b0;
    tick(3);
    @(negedge clk);
    held = if_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("stall_hold_pc", if_pc, held);
    end
    check32("stall_req_drop", {31'b0, imem_req}, 32'd0);
    tick();
    n = log_q.size();
    stall_n = 1'b1;
    wait_log(n + 2, "stall_resume_wait");
    check_log("stall_resume_pc0", n, held);
    check_log("stall_resume_pc1", n + 1, held + 32'd4);

    // Flush + jump with two requests in flight
    mem_hold = 1'b1;
    k = 0;
    while (!(m_out == 2 && m_fifo.size() == 0) && k < 50) begin
      tick();
      k++;
    end
    check32("flush_setup_out", m_out, 2);
    n = log_q.size();
    flush = 1'b1; jump = 1'b1; jump_addr = 32'h0000_0100;
    tick();
    flush = 1'b0; jump = 1'b0; mem_hold = 1'b0;
    wait_log(n + 1, "flush_wait");
    check_log("flush_target_pc", n, 32'h0000_0100);

    // Unaligned redirect without flush, grant withheld to observe address
    imem_gnt = 1'b0;
    tick(6);
    jump = 1'b1; jump_addr = 32'h0000_0103;
    tick();
    jump = 1'b0;
    @(negedge clk);
    check32("align_req", {31'b0, imem_req}, 32'd1);
    check32("align_addr", imem_addr, 32'h0000_0100);
    tick();
    imem_gnt = 1'b1;

    // Address wrap at the top of the space
    n = log_q.size();
    flush = 1'b1; jump = 1'b1; jump_addr = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0; jump = 1'b0;
    wait_log(n + 3, "wrap_wait");
    check_log("wrap_pc0", n, 32'hFFFF_FFF8);
    check_log("wrap_pc1", n + 1, 32'hFFFF_FFFC);
    check_log("wrap_pc2", n + 2, 32'h0000_0000);

    // Reset with a request outstanding
    mem_hold = 1'b1;
    k = 0;
    while (m_out < 1 && k < 50) begin
      tick();
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check32("midrst_valid", {31'b0, if_valid}, 32'd0);
    check32("midrst_req", {31'b0, imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
    check32("midrst_addr", imem_addr, RST_PC);
    n = log_q.size();
    tick();
    wait_log(n + 1, "midrst_wait");
    check_log("midrst_pc", n, RST_PC);
    if (log_q.size() > n) check32("midrst_instr", log_q[n].instr, mem_word(RST_PC));

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
